// File: rtl/in_service_control.sv
// 8259A in-service control: INTA acknowledge sequencing, ISR, priority rotation
// and vector generation for the interrupt that won priority resolution.
module in_service_control #(
  parameter int NUM_LINES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] interrupt,
  input  logic                 inta_pulse,
  input  logic                 auto_eoi,
  input  logic                 rotate_on_aeoi,
  input  logic                 eoi_strobe,
  input  logic                 eoi_specific,
  input  logic                 eoi_rotate,
  input  logic [2:0]           eoi_level,
  input  logic [4:0]           vector_base,
  output logic                 int_out,
  output logic [NUM_LINES-1:0] clear_irr,
  output logic [NUM_LINES-1:0] in_service_register,
  output logic [NUM_LINES-1:0] highest_level_in_service,
  output logic [7:0]           data_out,
  output logic                 data_out_valid
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK1} state_t;

  state_t         state_q, state_d;
  logic [7:0]     captured_q, captured_d;
  logic [7:0]     isr_q, isr_d;
  logic [7:0]     hlis_q, hlis_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           spurious_q, spurious_d;

  logic [7:0]     set_bit, aeoi_clr, eoi_clr, clr_irr;
  logic [2:0]     rot_lvl, scan_lvl, ns_lvl;
  logic           ns_found;

  // Inputs are one-hot or zero, so OR-ing the indices is an exact encode.
  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] e;
    e = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) e = e | 3'(i);
    return e;
  endfunction

  // Non-specific EOI: scan starting one past the lowest-priority level.
  always_comb begin
    rot_lvl  = encode(hlis_q);
    scan_lvl = 3'd0;
    ns_lvl   = 3'd0;
    ns_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      scan_lvl = rot_lvl + 3'(i);
      if (!ns_found && isr_q[scan_lvl]) begin
        ns_found = 1'b1;
        ns_lvl   = scan_lvl;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    spurious_d = spurious_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    hlis_d     = hlis_q;
    set_bit    = 8'h00;
    aeoi_clr   = 8'h00;
    eoi_clr    = 8'h00;
    clr_irr    = 8'h00;

    case (state_q)
      IDLE: begin
        if (interrupt != 8'h00) begin
          captured_d = interrupt;
          state_d    = PENDING;
        end
      end
      PENDING: begin
        if (inta_pulse) begin
          if (interrupt != 8'h00) begin
            captured_d = interrupt;
            set_bit    = interrupt;
            clr_irr    = interrupt;
          end else begin
            spurious_d = 1'b1;
          end
          state_d = ACK1;
        end
      end
      ACK1: begin
        if (inta_pulse) begin
          data_d  = spurious_q ? {vector_base, 3'b111}
                               : {vector_base, encode(captured_q)};
          valid_d = 1'b1;
          if (auto_eoi && !spurious_q) begin
            aeoi_clr = captured_q;
            if (rotate_on_aeoi) hlis_d = captured_q;
          end
          spurious_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI applies in any state; its rotation overrides an AEOI rotation.
    if (eoi_strobe) begin
      if (eoi_specific) begin
        eoi_clr = 8'b1 << eoi_level;
        if (eoi_rotate) hlis_d = 8'b1 << eoi_level;
      end else if (ns_found) begin
        eoi_clr = 8'b1 << ns_lvl;
        if (eoi_rotate) hlis_d = 8'b1 << ns_lvl;
      end
    end

    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | set_bit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      captured_q <= 8'h00;
      spurious_q <= 1'b0;
      isr_q      <= 8'h00;
      hlis_q     <= 8'h80;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      spurious_q <= spurious_d;
      isr_q      <= isr_d;
      hlis_q     <= hlis_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  // Gating with reset makes INT and IRR clears drop without waiting for an edge.
  assign int_out                  = (state_q == PENDING) && !reset;
  assign clear_irr                = reset ? 8'h00 : clr_irr;
  assign in_service_register      = isr_q;
  assign highest_level_in_service = hlis_q;
  assign data_out                 = data_q;
  assign data_out_valid           = valid_q;

endmodule
